// File: rtl/venus_pkg.sv
// Shared constants for the decode stage: opcode values, instruction field
// positions and register-index width.
package venus_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;
    localparam int OP_W     = 6;
    localparam int IMM_W    = 16;

    localparam int OP_LSB  = 26;
    localparam int RD_LSB  = 21;
    localparam int RS_LSB  = 16;
    localparam int RT_LSB  = 11;
    localparam int IMM_LSB = 0;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_NOP  = 6'd0;
    localparam opcode_t OP_ADD  = 6'd1;
    localparam opcode_t OP_SUB  = 6'd2;
    localparam opcode_t OP_AND  = 6'd3;
    localparam opcode_t OP_OR   = 6'd4;
    localparam opcode_t OP_ADDI = 6'd5;
    localparam opcode_t OP_LD   = 6'd6;
    localparam opcode_t OP_ST   = 6'd7;
    localparam opcode_t OP_JMP  = 6'd8;
    localparam opcode_t OP_BEZ  = 6'd9;

    // Ops that produce a register result (ADD..LD).
    function automatic logic writes_rd(input opcode_t op);
        return (op >= OP_ADD) && (op <= OP_LD);
    endfunction

endpackage

// File: rtl/regfile.sv
// 32 x WORD register file: three combinational read ports, one write port.
// A read of the register being written this cycle returns the incoming data.
module regfile
    import venus_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_addr,
    input  logic [REG_W-1:0] rt_addr,
    input  logic [REG_W-1:0] rd_addr,
    output logic [WORD-1:0]  rs_data,
    output logic [WORD-1:0]  rt_data,
    output logic [WORD-1:0]  rd_data,
    input  logic             wb_en,
    input  logic [REG_W-1:0] wb_addr,
    input  logic [WORD-1:0]  wb_data
);

    logic [WORD-1:0] regs [NUM_REGS];

    assign rs_data = (rs_addr == '0) ? '0 : (wb_en && wb_addr == rs_addr) ? wb_data : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : (wb_en && wb_addr == rt_addr) ? wb_data : regs[rt_addr];
    assign rd_data = (rd_addr == '0) ? '0 : (wb_en && wb_addr == rd_addr) ? wb_data : regs[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

endmodule

// File: rtl/idecode.sv
// Instruction decode stage: register read, load-use / branch-operand hazard
// stall, jump/branch resolution and one registered micro-op per cycle.
module idecode
    import venus_pkg::*;
#(
    parameter int ADDR = 16,
    parameter int WORD = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WORD-1:0]  inst_i,
    input  logic             wb_en_i,
    input  logic [REG_W-1:0] wb_addr_i,
    input  logic [WORD-1:0]  wb_data_i,
    output logic             stall_o,
    output logic             branch_o,
    output logic [ADDR-1:0]  branch_addr_o,
    output logic             valid_o,
    output logic [OP_W-1:0]  op_o,
    output logic [REG_W-1:0] rd_o,
    output logic [WORD-1:0]  a_o,
    output logic [WORD-1:0]  b_o,
    output logic [WORD-1:0]  imm_o,
    output logic             illegal_o
);

    logic [WORD-1:0]  hold_q;
    logic             hold_vld;
    logic             squash;
    logic             prev_vld;
    opcode_t          prev_op;
    logic [REG_W-1:0] prev_rd;

    logic [WORD-1:0]  inst;
    opcode_t          op;
    logic [REG_W-1:0] rd, rs, rt;
    logic [WORD-1:0]  rs_data, rt_data, rd_data;
    logic [WORD-1:0]  imm_ext;

    logic reads_rs, reads_rt, reads_rd, legal;
    logic hazard, take_branch, issue, illegal;
    logic [WORD-1:0] a_next, b_next;

    // After a stall the captured word is decoded; fetch's replay is ignored.
    assign inst    = hold_vld ? hold_q : inst_i;
    assign op      = inst[OP_LSB +: OP_W];
    assign rd      = inst[RD_LSB +: REG_W];
    assign rs      = inst[RS_LSB +: REG_W];
    assign rt      = inst[RT_LSB +: REG_W];
    assign imm_ext = {{(WORD-IMM_W){inst[IMM_LSB+IMM_W-1]}}, inst[IMM_LSB +: IMM_W]};

    regfile #(.WORD(WORD)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (rs),
        .rt_addr (rt),
        .rd_addr (rd),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .rd_data (rd_data),
        .wb_en   (wb_en_i),
        .wb_addr (wb_addr_i),
        .wb_data (wb_data_i)
    );

    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        reads_rd = 1'b0;
        legal    = 1'b1;
        case (op)
            OP_NOP, OP_JMP: begin end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_ADDI, OP_LD, OP_BEZ: reads_rs = 1'b1;
            OP_ST: begin
                reads_rs = 1'b1;
                reads_rd = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        hazard = 1'b0;
        if (!squash && !hold_vld && prev_vld && prev_rd != '0) begin
            if (prev_op == OP_LD && ((reads_rs && rs == prev_rd) ||
                                     (reads_rt && rt == prev_rd) ||
                                     (reads_rd && rd == prev_rd))) begin
                hazard = 1'b1;
            end
            if (op == OP_BEZ && writes_rd(prev_op) && rs == prev_rd) begin
                hazard = 1'b1;
            end
        end

        // Stall wins over branch; the branch resolves in the replay cycle.
        take_branch = !squash && !hazard &&
                      (op == OP_JMP || (op == OP_BEZ && rs_data == '0));

        issue   = !squash && !hazard && legal && op != OP_JMP && op != OP_BEZ;
        illegal = !squash && !legal;

        a_next = reads_rs ? rs_data : '0;
        b_next = reads_rt ? rt_data : (reads_rd ? rd_data : '0);
    end

    assign stall_o       = hazard;
    assign branch_o      = take_branch;
    assign branch_addr_o = take_branch ? inst[ADDR-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            hold_vld  <= 1'b0;
            squash    <= 1'b0;
            prev_vld  <= 1'b0;
            prev_op   <= OP_NOP;
            prev_rd   <= '0;
            valid_o   <= 1'b0;
            op_o      <= '0;
            rd_o      <= '0;
            a_o       <= '0;
            b_o       <= '0;
            imm_o     <= '0;
            illegal_o <= 1'b0;
        end else begin
            hold_vld <= hazard;
            if (hazard) begin
                hold_q <= inst_i;
            end
            squash    <= take_branch;
            prev_vld  <= issue;
            prev_op   <= op;
            prev_rd   <= rd;
            valid_o   <= issue;
            illegal_o <= illegal;
            op_o      <= issue ? op : '0;
            rd_o      <= issue ? rd : '0;
            a_o       <= issue ? a_next : '0;
            b_o       <= issue ? b_next : '0;
            imm_o     <= issue ? imm_ext : '0;
        end
    end

endmodule

// File: tb/tb_idecode.sv
// Bench for idecode: a table of per-cycle vectors with combinational checks,
// registered-output expectations through a scoreboard queue, and a reset-mid-stall sequence.
module tb_idecode;

    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        ill;
    } out_t;

    typedef struct {
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        stall;
        logic        br;
        logic [15:0] baddr;
        out_t        o;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        stall_o;
    logic        branch_o;
    logic [15:0] branch_addr_o;
    logic        valid_o;
    logic [5:0]  op_o;
    logic [4:0]  rd_o;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    int   errors = 0;
    int   checks = 0;
    out_t sb[$];
    vec_t vecs[18];

    idecode #(.ADDR(16), .WORD(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_i        (inst_i),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .stall_o       (stall_o),
        .branch_o      (branch_o),
        .branch_addr_o (branch_addr_o),
        .valid_o       (valid_o),
        .op_o          (op_o),
        .rd_o          (rd_o),
        .a_o           (a_o),
        .b_o           (b_o),
        .imm_o         (imm_o),
        .illegal_o     (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] enc_r(input int op, input int rd, input int rs, input int rt);
        return {op[5:0], rd[4:0], rs[4:0], rt[4:0], 11'b0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
        return {op[5:0], rd[4:0], rs[4:0], imm[15:0]};
    endfunction

    function automatic out_t mk_out(input logic v, input int op, input int rd,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] imm, input logic ill);
        out_t o;
        o.v = v; o.op = op[5:0]; o.rd = rd[4:0]; o.a = a; o.b = b; o.imm = imm; o.ill = ill;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic [31:0] inst, input logic wen, input int wa,
                                    input logic [31:0] wd, input logic stall, input logic br,
                                    input logic [15:0] baddr, input out_t o);
        vec_t r;
        r.inst = inst; r.wen = wen; r.wa = wa[4:0]; r.wd = wd;
        r.stall = stall; r.br = br; r.baddr = baddr; r.o = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input out_t e);
        chk({tag, ".valid"},   32'(valid_o),   32'(e.v));
        chk({tag, ".op"},      32'(op_o),      32'(e.op));
        chk({tag, ".rd"},      32'(rd_o),      32'(e.rd));
        chk({tag, ".a"},       a_o,            e.a);
        chk({tag, ".b"},       b_o,            e.b);
        chk({tag, ".imm"},     imm_o,          e.imm);
        chk({tag, ".illegal"}, 32'(illegal_o), 32'(e.ill));
    endtask

    // One cycle: drive, check the combinational outputs, queue the expected
    // registered result, then pop and compare it after the edge.
    task automatic step(input string tag, input vec_t v);
        out_t e;
        inst_i    = v.inst;
        wb_en_i   = v.wen;
        wb_addr_i = v.wa;
        wb_data_i = v.wd;
        #1;
        chk({tag, ".stall"},  32'(stall_o),       32'(v.stall));
        chk({tag, ".branch"}, 32'(branch_o),      32'(v.br));
        chk({tag, ".baddr"},  32'(branch_addr_o), 32'(v.baddr));
        sb.push_back(v.o);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk_out(tag, e);
        end
    endtask

    initial begin
        out_t bub;
        out_t zero_o;
        bub    = '0;
        zero_o = '0;

        vecs[0]  = mk_vec(enc_i(5, 1, 0, 5),        1'b0, 0, 0,        1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 5, 1, 0, 0, 32'h5, 1'b0));
        vecs[1]  = mk_vec(enc_r(1, 2, 1, 1),        1'b1, 1, 32'h5,    1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 1, 2, 32'h5, 32'h5, 32'h800, 1'b0));
        vecs[2]  = mk_vec(enc_i(6, 3, 1, 4),        1'b0, 0, 0,        1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 6, 3, 32'h5, 0, 32'h4, 1'b0));
        vecs[3]  = mk_vec(enc_r(1, 4, 3, 1),        1'b0, 0, 0,        1'b1, 1'b0, 16'h0, bub);
        vecs[4]  = mk_vec(enc_r(1, 9, 1, 1),        1'b1, 3, 32'h77,   1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 1, 4, 32'h77, 32'h5, 32'h800, 1'b0));
        vecs[5]  = mk_vec(enc_i(8, 0, 0, 16'h0040), 1'b0, 0, 0,        1'b0, 1'b1, 16'h0040, bub);
        vecs[6]  = mk_vec(enc_i(5, 7, 0, 1),        1'b0, 0, 0,        1'b0, 1'b0, 16'h0, bub);
        vecs[7]  = mk_vec(enc_i(5, 5, 0, 0),        1'b1, 5, 32'h99,   1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 5, 5, 0, 0, 0, 1'b0));
        vecs[8]  = mk_vec(enc_i(9, 0, 5, 16'h0010), 1'b0, 0, 0,        1'b1, 1'b0, 16'h0, bub);
        vecs[9]  = mk_vec(enc_i(9, 0, 5, 16'h0010), 1'b1, 5, 32'h0,    1'b0, 1'b1, 16'h0010, bub);
        vecs[10] = mk_vec(enc_i(5, 6, 0, 3),        1'b0, 0, 0,        1'b0, 1'b0, 16'h0, bub);
        vecs[11] = mk_vec(32'hFC00_0000,            1'b0, 0, 0,        1'b0, 1'b0, 16'h0,
                          mk_out(1'b0, 0, 0, 0, 0, 0, 1'b1));
        vecs[12] = mk_vec(enc_r(1, 8, 1, 5),        1'b0, 0, 0,        1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 1, 8, 32'h5, 0, 32'h2800, 1'b0));
        vecs[13] = mk_vec(enc_i(7, 1, 3, 8),        1'b0, 0, 0,        1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 7, 1, 32'h77, 32'h5, 32'h8, 1'b0));
        vecs[14] = mk_vec(enc_i(9, 0, 1, 16'h0020), 1'b0, 0, 0,        1'b0, 1'b0, 16'h0, bub);
        vecs[15] = mk_vec(32'h0,                    1'b1, 0, 32'hDEAD, 1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 0, 0, 0, 0, 0, 1'b0));
        vecs[16] = mk_vec(enc_r(1, 10, 0, 0),       1'b1, 0, 32'h1234, 1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 1, 10, 0, 0, 0, 1'b0));
        vecs[17] = mk_vec(enc_i(5, 11, 1, 16'h8001), 1'b0, 0, 0,       1'b0, 1'b0, 16'h0,
                          mk_out(1'b1, 5, 11, 32'h5, 0, 32'hFFFF_8001, 1'b0));

        rst       = 1'b1;
        inst_i    = '0;
        wb_en_i   = 1'b0;
        wb_addr_i = '0;
        wb_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall",  32'(stall_o),  32'h0);
        chk("reset.branch", 32'(branch_o), 32'h0);
        chk_out("reset", zero_o);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step($sformatf("v%0d", i), vecs[i]);
        end

        // Reset arrives while an ADD is stalled behind a load.
        step("rs0", mk_vec(enc_i(6, 12, 1, 0), 1'b0, 0, 0, 1'b0, 1'b0, 16'h0,
                           mk_out(1'b1, 6, 12, 32'h5, 0, 0, 1'b0)));
        inst_i = enc_r(1, 13, 12, 1);
        #1;
        chk("rs1.stall", 32'(stall_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("rs1.stall_in_reset", 32'(stall_o), 32'h0);
        chk_out("rs1", zero_o);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_out("rs2", zero_o);
        step("rs3", mk_vec(enc_r(1, 9, 1, 1), 1'b0, 0, 0, 1'b0, 1'b0, 16'h0,
                           mk_out(1'b1, 1, 9, 0, 0, 32'h800, 1'b0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idecode.md
# idecode

Instruction decode stage. Sits directly downstream of instruction fetch: consumes the registered instruction word, reads the 32×32 register file, detects load-use and branch-operand hazards, resolves jumps/branches, and issues one decoded micro-op per cycle to execute. Drives fetch's `stall_i`, `branch_i` and `branch_addr_i`.

## Interface
- `ADDR`, 16, instruction address width
- `WORD`, 32, instruction/data width
- `clk` in 1 clock
- `rst` in 1 asynchronous reset, active-high
- `inst_i` in WORD instruction from fetch
- `wb_en_i` in 1 register write enable from writeback
- `wb_addr_i` in 5 writeback register index
- `wb_data_i` in WORD writeback data
- `stall_o` in→fetch out 1 hold fetch PC this cycle
- `branch_o` out 1 redirect fetch
- `branch_addr_o` out ADDR redirect target
- `valid_o` out 1 issued op is real (0 = bubble)
- `op_o` out 6 opcode
- `rd_o` out 5 destination register
- `a_o`, `b_o` out WORD operand values (rs; rt or rd for ST)
- `imm_o` out WORD sign-extended imm16
- `illegal_o` out 1 undefined opcode issued as bubble

## Operation
- Fields: op [31:26], rd [25:21], rs [20:16], rt [15:11], imm [15:0].
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR (read rs, rt); 5 ADDI, 6 LD (read rs); 7 ST (read rs, rd as data); 8 JMP; 9 BEZ (read rs). Opcodes 10–63: bubble, `illegal_o`=1 for that cycle.
- r0 reads 0; writes to r0 ignored. Writeback is write-first: a read of `wb_addr_i` in the write cycle returns `wb_data_i`.
- Hazard (combinational, vs. previous issued op P, valid, rd≠0):
  - P is LD and current reads P.rd, or current is BEZ and P writes rs (ADD..LD): `stall_o`=1.
  - Other distance-1 dependencies are left to execute forwarding. Distance-2 dependencies are covered by the writeback bypass.
- Stall cycle: bubble issued, current instruction captured in hold register. Next cycle the hold instruction is decoded and `inst_i` is discarded, since fetch replays the same word. Maximum one consecutive stall cycle per instruction.
- JMP: `branch_o`=1, `branch_addr_o`=imm[ADDR-1:0]. BEZ: same when `a_o`==0. The instruction is issued as a bubble to execute. The next cycle's `inst_i` (wrong path) is squashed to a bubble via a squash flag.
- `branch_o` is never asserted while `stall_o`=1. Stall has priority; the branch resolves in the replay cycle.
- State: hold register + hold-valid flag, squash flag, previous-op (op, rd, valid), output registers.

## Timing
- Outputs to execute are registered: an instruction on `inst_i` in cycle t appears on `valid_o`/`op_o`/... in cycle t+1. A stalled instruction appears in t+2.
- `stall_o`, `branch_o`, `branch_addr_o` are combinational from the current instruction and state, and are sampled by fetch at the same edge.
- Reset: all outputs 0, register file cleared, hold/squash/previous-op invalid. `inst_i`=0 decodes as NOP.
- Squash and hold are mutually exclusive. A squashed cycle clears previous-op, so no stall is raised from it.
- Reset mid-stall or mid-squash: all state is dropped, no pending replay.

## Structure
- Package `venus_pkg`: opcode constants, field bit positions, register-index width.
- Sub-module `regfile`: 32×WORD, two combinational read ports plus rd read for ST, one write port with write-first bypass, r0 forced zero.

## Test plan
- Reset, then ADDI r1,r0,5; ADD r2,r1,r1 → `valid_o` both cycles, no stall; `b_o`=`a_o` forwarded by execute.
- LD r3; ADD r4,r3,r1 → `stall_o`=1 one cycle, bubble, then ADD issued with `rd_o`=4. Fetch replay word is discarded.
- JMP 0x0040 → `branch_o`=1, `branch_addr_o`=0x0040, JMP issues bubble, following word squashed (`valid_o`=0).
- ADDI r5,r0,0; BEZ r5,0x0010 → one stall cycle. The replay gets r5 from the writeback bypass and branches to 0x0010.
- Opcode 0x3F → `illegal_o`=1, `valid_o`=0. Pipeline continues normally.
- Assert `rst` during a stall cycle → all outputs 0 next cycle, no replay after release.
